// File: rtl/alu_share_arbiter_pkg.sv
// Shared widths, types and ALU opcode encodings for the ALU share arbiter and its requesters.
package alu_share_arbiter_pkg;

    localparam int XLEN  = 32;
    localparam int OPC_W = 4;

    typedef logic [XLEN-1:0]  xlen_t;
    typedef logic [OPC_W-1:0] opc_t;

    typedef enum logic [OPC_W-1:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_SRA  = 4'b1101
    } alu_opcode_e;

    // Index of the winner encoded in a one-hot two-way grant.
    function automatic logic grant_idx(input logic [1:0] grant);
        return grant[1];
    endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Bundle of request, response and shared-ALU signals between two requesters and the arbiter.
interface alu_share_if;
    import alu_share_arbiter_pkg::*;

    logic  req0_valid_in;
    logic  req0_ready_out;
    xlen_t req0_op_1_in;
    xlen_t req0_op_2_in;
    opc_t  req0_opcode_in;
    logic  req1_valid_in;
    logic  req1_ready_out;
    xlen_t req1_op_1_in;
    xlen_t req1_op_2_in;
    opc_t  req1_opcode_in;

    logic  rsp0_valid_out;
    logic  rsp0_ready_in;
    xlen_t rsp0_data_out;
    logic  rsp1_valid_out;
    logic  rsp1_ready_in;
    xlen_t rsp1_data_out;

    xlen_t alu_op_1_out;
    xlen_t alu_op_2_out;
    opc_t  alu_opcode_out;
    xlen_t alu_result_in;

    modport slave (
        input  req0_valid_in, req0_op_1_in, req0_op_2_in, req0_opcode_in,
        input  req1_valid_in, req1_op_1_in, req1_op_2_in, req1_opcode_in,
        output req0_ready_out, req1_ready_out,
        output rsp0_valid_out, rsp0_data_out, rsp1_valid_out, rsp1_data_out,
        input  rsp0_ready_in, rsp1_ready_in,
        output alu_op_1_out, alu_op_2_out, alu_opcode_out,
        input  alu_result_in
    );

    modport master (
        output req0_valid_in, req0_op_1_in, req0_op_2_in, req0_opcode_in,
        output req1_valid_in, req1_op_1_in, req1_op_2_in, req1_opcode_in,
        input  req0_ready_out, req1_ready_out,
        input  rsp0_valid_out, rsp0_data_out, rsp1_valid_out, rsp1_data_out,
        output rsp0_ready_in, rsp1_ready_in,
        input  alu_op_1_out, alu_op_2_out, alu_opcode_out,
        output alu_result_in
    );

endinterface

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way arbiter: one-hot grant from eligibility, either fixed priority to req0 or
// round-robin against the previous winner.
module rr_arb2
    import alu_share_arbiter_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic [1:0] eligible_in,
    input  logic       last_grant_in,
    output logic [1:0] grant_out
);

    // Tie resolution: req0 under fixed priority, otherwise whoever did not win last.
    always_comb begin
        grant_out = 2'b00;
        case (eligible_in)
            2'b01:   grant_out = 2'b01;
            2'b10:   grant_out = 2'b10;
            2'b11: begin
                if (FIXED_PRIO) begin
                    grant_out = 2'b01;
                end else if (last_grant_in) begin
                    grant_out = 2'b01;
                end else begin
                    grant_out = 2'b10;
                end
            end
            default: grant_out = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters; the result is captured into a
// per-requester one-entry response buffer one cycle after acceptance.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    alu_share_if.slave  bus
);

    logic [1:0] req_valid;
    logic [1:0] rsp_ready;
    logic [1:0] eligible;
    logic [1:0] grant;
    logic [1:0] rsp_valid_d;
    logic [1:0] rsp_valid_q;
    xlen_t      rsp_data_d [2];
    xlen_t      rsp_data_q [2];
    logic       last_grant_d;
    logic       last_grant_q;

    assign req_valid = {bus.req1_valid_in, bus.req0_valid_in};
    assign rsp_ready = {bus.rsp1_ready_in, bus.rsp0_ready_in};

    // A requester may win only if its buffer is empty or being drained this cycle.
    always_comb begin
        eligible = req_valid & (~rsp_valid_q | rsp_ready);
    end

    rr_arb2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
        .eligible_in   (eligible),
        .last_grant_in (last_grant_q),
        .grant_out     (grant)
    );

    assign bus.req0_ready_out = grant[0] & ~rst_in;
    assign bus.req1_ready_out = grant[1] & ~rst_in;

    // Operand mux; zeros when idle so the ALU sees a harmless add of 0 + 0.
    always_comb begin
        bus.alu_op_1_out   = '0;
        bus.alu_op_2_out   = '0;
        bus.alu_opcode_out = '0;
        if (grant[0]) begin
            bus.alu_op_1_out   = bus.req0_op_1_in;
            bus.alu_op_2_out   = bus.req0_op_2_in;
            bus.alu_opcode_out = bus.req0_opcode_in;
        end else if (grant[1]) begin
            bus.alu_op_1_out   = bus.req1_op_1_in;
            bus.alu_op_2_out   = bus.req1_op_2_in;
            bus.alu_opcode_out = bus.req1_opcode_in;
        end else begin
            bus.alu_op_1_out   = '0;
            bus.alu_op_2_out   = '0;
            bus.alu_opcode_out = '0;
        end
    end

    // Response buffers: a fresh grant overrides a concurrent drain so back-to-back ops need no bubble.
    always_comb begin
        rsp_valid_d  = rsp_valid_q;
        last_grant_d = last_grant_q;
        for (int n = 0; n < 2; n++) begin
            rsp_data_d[n] = rsp_data_q[n];
            if (grant[n]) begin
                rsp_valid_d[n] = 1'b1;
                rsp_data_d[n]  = bus.alu_result_in;
            end else if (rsp_ready[n]) begin
                rsp_valid_d[n] = 1'b0;
            end else begin
                rsp_valid_d[n] = rsp_valid_q[n];
            end
        end
        if (|grant) begin
            last_grant_d = grant_idx(grant);
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    // State registers; last_grant resets to req1 so req0 wins the first tie.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rsp_valid_q   <= 2'b00;
            rsp_data_q[0] <= '0;
            rsp_data_q[1] <= '0;
            last_grant_q  <= 1'b1;
        end else begin
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q[0] <= rsp_data_d[0];
            rsp_data_q[1] <= rsp_data_d[1];
            last_grant_q  <= last_grant_d;
        end
    end

    assign bus.rsp0_valid_out = rsp_valid_q[0];
    assign bus.rsp1_valid_out = rsp_valid_q[1];
    assign bus.rsp0_data_out  = rsp_data_q[0];
    assign bus.rsp1_data_out  = rsp_data_q[1];

endmodule
